// File: rtl/span_mask_renderer_if.sv
// Span-table write channel for span_mask_renderer.
//   wr_valid / wr_ready : request / accept, a write commits when both are high
//   wr_row              : target row of the span table
//   wr_idx              : span slot within the row
//   wr_x0 / wr_x1       : inclusive span start / end (shape coordinates)
//   wr_en               : slot enable, 0 clears the slot
// master drives the request side, slave (the renderer) returns wr_ready.
interface span_mask_renderer_if #(
  parameter int XW = 7,
  parameter int YW = 7,
  parameter int IW = 2
);
  logic          wr_valid;
  logic          wr_ready;
  logic [YW-1:0] wr_row;
  logic [IW-1:0] wr_idx;
  logic [XW-1:0] wr_x0;
  logic [XW-1:0] wr_x1;
  logic          wr_en;

  modport master (
    output wr_valid, wr_row, wr_idx, wr_x0, wr_x1, wr_en,
    input  wr_ready
  );

  modport slave (
    input  wr_valid, wr_row, wr_idx, wr_x0, wr_x1, wr_en,
    output wr_ready
  );
endinterface

// File: rtl/span_mask_renderer.sv
// Span-table outline mask renderer for the 96x64 OLED pixel pipeline.
// The outline is a table of up to MAX_SPANS horizontal runs per row, placed
// at a per-frame origin with optional horizontal mirroring. Produces a
// registered per-pixel mask (2-cycle latency) plus a per-frame count of
// pixels where the mask overlaps a second object mask.
//
// Ports:
//   clk50, rst_n        : clock, synchronous active-low reset
//   frame_start         : pulse before first pixel; latches org_x/org_y/flip_x
//                         and rolls the collision count into hit_count_last
//   pix_valid, x, y     : pixel coordinate stream
//   coll_in             : other-object mask aligned with x/y
//   wr                  : span-table write channel (slave modport)
//   map, map_valid, hit : registered mask, qualifier, mask & coll_in
//   hit_count_last      : collisions counted in the previous frame
//   busy                : table clear in progress
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_CLEAR | walk rows 0..ROWS-1 disabling every slot, writes refused
// ST_RUN   | normal operation, writes accepted, pixels rendered
module span_mask_renderer #(
  parameter int XW        = 7,
  parameter int YW        = 7,
  parameter int ROWS      = 56,
  parameter int SHAPE_W   = 96,
  parameter int MAX_SPANS = 4,
  parameter int CNT_W     = 16
) (
  input  logic             clk50,
  input  logic             rst_n,
  input  logic             frame_start,
  input  logic [XW-1:0]    org_x,
  input  logic [YW-1:0]    org_y,
  input  logic             flip_x,
  input  logic             pix_valid,
  input  logic [XW-1:0]    x,
  input  logic [YW-1:0]    y,
  input  logic             coll_in,
  span_mask_renderer_if.slave wr,
  output logic             map,
  output logic             map_valid,
  output logic             hit,
  output logic [CNT_W-1:0] hit_count_last,
  output logic             busy
);

  localparam int RAW = $clog2(ROWS);
  localparam logic [RAW-1:0] ROW_LAST = RAW'(ROWS - 1);
  localparam logic [XW:0]    SW_L     = (XW+1)'(SHAPE_W);
  localparam logic [XW-1:0]  SW_M1    = XW'(SHAPE_W - 1);
  localparam logic [YW:0]    ROWS_L   = (YW+1)'(ROWS);

  typedef enum logic [0:0] {ST_CLEAR, ST_RUN} state_t;

  state_t         state;
  logic [RAW-1:0] clr_row;

  // span table
  logic [MAX_SPANS-1:0] tbl_en [ROWS];
  logic [XW-1:0]        tbl_x0 [ROWS][MAX_SPANS];
  logic [XW-1:0]        tbl_x1 [ROWS][MAX_SPANS];

  // frame registers
  logic [XW-1:0]    org_x_q;
  logic [YW-1:0]    org_y_q;
  logic             flip_q;
  logic [CNT_W-1:0] hit_cnt;

  // stage-1 combinational
  logic [XW-1:0]  org_x_eff;
  logic [YW-1:0]  org_y_eff;
  logic           flip_eff;
  logic [XW:0]    dx;
  logic [YW:0]    dy;
  logic           in_range;
  logic [XW-1:0]  rx;
  logic [RAW-1:0] rd_row;

  // stage-1 registers
  logic                 s1_valid;
  logic                 s1_in;
  logic [XW-1:0]        s1_rx;
  logic                 s1_coll;
  logic [MAX_SPANS-1:0] s1_en;
  logic [XW-1:0]        s1_x0 [MAX_SPANS];
  logic [XW-1:0]        s1_x1 [MAX_SPANS];

  logic           match;
  logic           hit_next;
  logic           wr_fire;
  logic [RAW-1:0] wr_row_i;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk50) begin
    if (!rst_n) begin
      state       <= ST_CLEAR;
      clr_row     <= '0;
      busy        <= 1'b1;
      wr.wr_ready <= 1'b0;
    end else begin
      case (state)
        ST_CLEAR: begin
          if (clr_row == ROW_LAST) begin
            state       <= ST_RUN;
            busy        <= 1'b0;
            wr.wr_ready <= 1'b1;
          end else begin
            clr_row <= clr_row + 1'b1;
          end
        end
        ST_RUN: begin
          busy        <= 1'b0;
          wr.wr_ready <= 1'b1;
        end
        default: state <= ST_CLEAR;
      endcase
    end
  end

  // ------------------------------------------------------------ span table
  // Rows beyond the table are accepted by the handshake but never stored.
  // A write landing on the reset edge is dropped so reset wins mid-write.
  assign wr_row_i = wr.wr_row[RAW-1:0];
  assign wr_fire  = rst_n && wr.wr_valid && wr.wr_ready &&
                    ({1'b0, wr.wr_row} < ROWS_L);

  always_ff @(posedge clk50) begin
    if (state == ST_CLEAR) begin
      tbl_en[clr_row] <= '0;
    end else if (wr_fire) begin
      tbl_en[wr_row_i][wr.wr_idx] <= wr.wr_en;
      tbl_x0[wr_row_i][wr.wr_idx] <= wr.wr_x0;
      tbl_x1[wr_row_i][wr.wr_idx] <= wr.wr_x1;
    end
  end

  // ------------------------------------------------------- stage 1 compute
  // A pixel arriving with frame_start already uses the new origin/flip.
  always_comb begin
    org_x_eff = frame_start ? org_x  : org_x_q;
    org_y_eff = frame_start ? org_y  : org_y_q;
    flip_eff  = frame_start ? flip_x : flip_q;
    dx = {1'b0, x} - {1'b0, org_x_eff};
    dy = {1'b0, y} - {1'b0, org_y_eff};
    // A borrow sets the top bit, so the unsigned compares also reject
    // negative offsets instead of letting them wrap into the shape.
    in_range = (dx < SW_L) && (dy < ROWS_L);
    rx       = flip_eff ? (SW_M1 - dx[XW-1:0]) : dx[XW-1:0];
    rd_row   = in_range ? dy[RAW-1:0] : '0;
  end

  // Row data read on the same edge a write may commit: old contents are
  // captured, the write becomes visible to the next pixel.
  always_ff @(posedge clk50) begin
    s1_en <= tbl_en[rd_row];
    s1_x0 <= tbl_x0[rd_row];
    s1_x1 <= tbl_x1[rd_row];
  end

  always_ff @(posedge clk50) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_in     <= 1'b0;
      s1_rx     <= '0;
      s1_coll   <= 1'b0;
      map       <= 1'b0;
      map_valid <= 1'b0;
      hit       <= 1'b0;
    end else begin
      s1_valid  <= pix_valid && (state == ST_RUN);
      s1_in     <= in_range;
      s1_rx     <= rx;
      s1_coll   <= coll_in;
      map       <= s1_valid && match;
      map_valid <= s1_valid;
      hit       <= hit_next;
    end
  end

  // ------------------------------------------------------- stage 2 compare
  // x0 > x1 can never satisfy both bounds, so inverted spans never match.
  always_comb begin
    match = 1'b0;
    for (int i = 0; i < MAX_SPANS; i++) begin
      if (s1_en[i] && (s1_x0[i] <= s1_rx) && (s1_rx <= s1_x1[i]))
        match = 1'b1;
    end
    match    = match && s1_in;
    hit_next = s1_valid && match && s1_coll;
  end

  // ------------------------------------------------ frame regs and counter
  // Hits are counted as they are resolved in stage 2, so a pixel still in
  // the pipeline at frame_start is credited to the frame it belonged to.
  logic [CNT_W-1:0] cnt_next;
  assign cnt_next = (hit_next && (hit_cnt != '1)) ? hit_cnt + 1'b1 : hit_cnt;

  always_ff @(posedge clk50) begin
    if (!rst_n) begin
      org_x_q        <= '0;
      org_y_q        <= '0;
      flip_q         <= 1'b0;
      hit_cnt        <= '0;
      hit_count_last <= '0;
    end else if (frame_start) begin
      org_x_q        <= org_x;
      org_y_q        <= org_y;
      flip_q         <= flip_x;
      hit_count_last <= cnt_next;
      hit_cnt        <= '0;
    end else begin
      hit_cnt <= cnt_next;
    end
  end

endmodule
